// File: rtl/proc_n.sv
// proc_n: parametrised multi-cycle bus processor with eight general registers,
// accumulator A, ALU result register G and a one-hot driven shared bus.
module proc_n #(
  parameter int W = 16
) (
  input  logic         Clock,
  input  logic         Resetn,
  input  logic [W-1:0] DIN,
  input  logic         Run,
  output logic         Done,
  output logic [W-1:0] BusWires
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_MVNZ = 3'd5;

  state_t         state_r;
  state_t         next_state_s;
  logic [8:0]     ir_r;
  logic [W-1:0]   a_r;
  logic [W-1:0]   g_r;
  logic [W-1:0]   r_r [8];

  logic [2:0]     opcode_s;
  logic [2:0]     x_s;
  logic [2:0]     y_s;
  logic           is_alu_s;
  logic           g_nz_s;

  logic           ir_in_s;
  logic           a_in_s;
  logic           g_in_s;
  logic [7:0]     r_in_s;
  logic           sel_din_s;
  logic           sel_g_s;
  logic [7:0]     sel_r_s;
  logic           done_s;
  logic [W-1:0]   bus_s;
  logic [W-1:0]   alu_s;

  // One-hot decode of a 3-bit register index.
  function automatic logic [7:0] dec3_f(input logic [2:0] idx);
    dec3_f = 8'b0000_0001 << idx;
  endfunction

  // ALU: results wrap modulo 2^W; subtraction is A + ~B + 1.
  function automatic logic [W-1:0] alu_f(input logic [2:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      OP_ADD:  alu_f = a + b;
      OP_SUB:  alu_f = a + ~b + {{(W-1){1'b0}}, 1'b1};
      OP_AND:  alu_f = a & b;
      default: alu_f = {W{1'b0}};
    endcase
  endfunction

  assign opcode_s = ir_r[8:6];
  assign x_s      = ir_r[5:3];
  assign y_s      = ir_r[2:0];
  assign is_alu_s = (opcode_s == OP_ADD) || (opcode_s == OP_SUB) || (opcode_s == OP_AND);
  assign g_nz_s   = (g_r != {W{1'b0}});

  // Control decode: bus source selects, register load enables, Done and next state.
  always_comb begin
    next_state_s = state_r;
    ir_in_s      = 1'b0;
    a_in_s       = 1'b0;
    g_in_s       = 1'b0;
    r_in_s       = 8'b0;
    sel_din_s    = 1'b0;
    sel_g_s      = 1'b0;
    sel_r_s      = 8'b0;
    done_s       = 1'b0;
    case (state_r)
      T0: begin
        if (Run) begin
          ir_in_s      = 1'b1;
          next_state_s = T1;
        end else begin
          next_state_s = T0;
        end
      end
      T1: begin
        case (opcode_s)
          OP_MV: begin
            sel_r_s      = dec3_f(y_s);
            r_in_s       = dec3_f(x_s);
            done_s       = 1'b1;
            next_state_s = T0;
          end
          OP_MVI: begin
            sel_din_s    = 1'b1;
            r_in_s       = dec3_f(x_s);
            done_s       = 1'b1;
            next_state_s = T0;
          end
          OP_MVNZ: begin
            sel_r_s = dec3_f(y_s);
            if (g_nz_s) begin
              r_in_s = dec3_f(x_s);
            end else begin
              r_in_s = 8'b0;
            end
            done_s       = 1'b1;
            next_state_s = T0;
          end
          OP_ADD, OP_SUB, OP_AND: begin
            sel_r_s      = dec3_f(x_s);
            a_in_s       = 1'b1;
            next_state_s = T2;
          end
          default: begin
            done_s       = 1'b1;
            next_state_s = T0;
          end
        endcase
      end
      T2: begin
        if (is_alu_s) begin
          sel_r_s      = dec3_f(y_s);
          g_in_s       = 1'b1;
          next_state_s = T3;
        end else begin
          next_state_s = T0;
        end
      end
      T3: begin
        if (is_alu_s) begin
          sel_g_s      = 1'b1;
          r_in_s       = dec3_f(x_s);
          done_s       = 1'b1;
          next_state_s = T0;
        end else begin
          next_state_s = T0;
        end
      end
      default: begin
        next_state_s = T0;
      end
    endcase
  end

  // Shared bus: AND-OR of one-hot selected sources, zero when nothing drives it.
  always_comb begin
    bus_s = (DIN & {W{sel_din_s}}) | (g_r & {W{sel_g_s}});
    for (int i = 0; i < 8; i++) begin
      bus_s = bus_s | (r_r[i] & {W{sel_r_s[i]}});
    end
  end

  assign alu_s    = alu_f(opcode_s, a_r, bus_s);
  assign Done     = done_s;
  assign BusWires = bus_s;

  // Sequencer state, instruction register, accumulator and ALU result register.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_r <= T0;
      ir_r    <= 9'd0;
      a_r     <= {W{1'b0}};
      g_r     <= {W{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (ir_in_s) begin
        ir_r <= DIN[8:0];
      end
      if (a_in_s) begin
        a_r <= bus_s;
      end
      if (g_in_s) begin
        g_r <= alu_s;
      end
    end
  end

  // General register file R0-R7, each loaded from the bus on its enable.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < 8; i++) begin
        r_r[i] <= {W{1'b0}};
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (r_in_s[i]) begin
          r_r[i] <= bus_s;
        end
      end
    end
  end

endmodule

// File: tb/tb_proc_n.sv
// Directed self-checking bench for proc_n: a W=16 instance runs the main program,
// a W=32 instance repeats the add/wrap case.
module tb_proc_n;

  logic        clk;
  logic        rst_n;
  logic [31:0] din;
  logic        run;
  logic        wide;

  logic        done16;
  logic [15:0] bus16;
  logic        done32;
  logic [31:0] bus32;

  logic        run16;
  logic        run32;
  logic        done_o;
  logic [31:0] bus_o;

  int n_cmp = 0;
  int n_err = 0;

  assign run16  = run & ~wide;
  assign run32  = run & wide;
  assign done_o = wide ? done32 : done16;
  assign bus_o  = wide ? bus32 : {16'd0, bus16};

  proc_n #(.W(16)) u_dut16 (
    .Clock(clk), .Resetn(rst_n), .DIN(din[15:0]), .Run(run16),
    .Done(done16), .BusWires(bus16)
  );

  proc_n #(.W(32)) u_dut32 (
    .Clock(clk), .Resetn(rst_n), .DIN(din), .Run(run32),
    .Done(done32), .BusWires(bus32)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
    ins = {op, x, y};
  endfunction

  // Runs one instruction starting just after a rising edge while in T0.
  task automatic exec(input string tag, input logic [8:0] instr, input logic [31:0] imm,
                      input logic [31:0] exp_bus);
    int n;
    n   = (instr[8:6] == 3'd2 || instr[8:6] == 3'd3 || instr[8:6] == 3'd4) ? 4 : 2;
    din = {23'd0, instr};
    run = 1'b1;
    @(negedge clk);
    check_val({tag, ".fetch_done"}, {63'd0, done_o}, 64'd0);
    @(posedge clk); #1;
    din = imm;
    for (int c = 2; c < n; c++) begin
      @(negedge clk);
      check_val({tag, ".mid_done"}, {63'd0, done_o}, 64'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val({tag, ".done"}, {63'd0, done_o}, 64'd1);
    check_val({tag, ".bus"}, {32'd0, bus_o}, {32'd0, exp_bus});
    @(posedge clk); #1;
    run = 1'b0;
  endtask

  // Observes Rk on the bus via "mv Rk,Rk", which leaves Rk unchanged.
  task automatic rd(input string tag, input logic [2:0] k, input logic [31:0] exp);
    exec(tag, ins(3'd0, k, k), 32'd0, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    din   = 32'd0;
    wide  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_done", {63'd0, done_o}, 64'd0);
    check_val("rst_bus", {32'd0, bus_o}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("idle_done", {63'd0, done_o}, 64'd0);
      check_val("idle_bus", {32'd0, bus_o}, 64'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) rd("rst_reg", k[2:0], 32'd0);

    // mvi then mv, back to back
    exec("mvi_r0", ins(3'd1, 3'd0, 3'd0), 32'h0005, 32'h0005);
    exec("mv_r1_r0", ins(3'd0, 3'd1, 3'd0), 32'h0000, 32'h0005);
    rd("r0", 3'd0, 32'h0005);
    rd("r1", 3'd1, 32'h0005);

    // add wrap, sub self
    exec("mvi_r2", ins(3'd1, 3'd2, 3'd0), 32'hFFFF, 32'hFFFF);
    exec("mvi_r3", ins(3'd1, 3'd3, 3'd0), 32'h0002, 32'h0002);
    exec("add_r2_r3", ins(3'd2, 3'd2, 3'd3), 32'h0000, 32'h0001);
    rd("r2_wrap", 3'd2, 32'h0001);
    exec("sub_r3_r3", ins(3'd3, 3'd3, 3'd3), 32'h0000, 32'h0000);
    rd("r3_zero", 3'd3, 32'h0000);

    // mvnz with G=0 then G=3
    exec("mvnz_g0", ins(3'd5, 3'd4, 3'd2), 32'h0000, 32'h0001);
    rd("r4_kept", 3'd4, 32'h0000);
    exec("mvi_r5", ins(3'd1, 3'd5, 3'd0), 32'h0002, 32'h0002);
    exec("add_r5_r2", ins(3'd2, 3'd5, 3'd2), 32'h0000, 32'h0003);
    exec("mvnz_g3", ins(3'd5, 3'd4, 3'd2), 32'h0000, 32'h0001);
    rd("r4_moved", 3'd4, 32'h0001);

    // and, then no-ops leave registers and G alone
    exec("mvi_r5b", ins(3'd1, 3'd5, 3'd0), 32'h0F0F, 32'h0F0F);
    exec("mvi_r6", ins(3'd1, 3'd6, 3'd0), 32'h00FF, 32'h00FF);
    exec("and_r5_r6", ins(3'd4, 3'd5, 3'd6), 32'h0000, 32'h000F);
    rd("r5_and", 3'd5, 32'h000F);
    exec("sub_g0", ins(3'd3, 3'd3, 3'd3), 32'h0000, 32'h0000);
    exec("nop110", ins(3'd6, 3'd6, 3'd5), 32'h0000, 32'h0000);
    exec("nop111", ins(3'd7, 3'd5, 3'd6), 32'h0000, 32'h0000);
    rd("r6_nop", 3'd6, 32'h00FF);
    rd("r5_nop", 3'd5, 32'h000F);
    exec("mvnz_after_nop", ins(3'd5, 3'd7, 3'd5), 32'h0000, 32'h000F);
    rd("r7_g_kept0", 3'd7, 32'h0000);

    // reset pulse during T2 of add aborts it
    exec("mvi_r2c", ins(3'd1, 3'd2, 3'd0), 32'h0005, 32'h0005);
    exec("mvi_r3c", ins(3'd1, 3'd3, 3'd0), 32'h0006, 32'h0006);
    din = {23'd0, ins(3'd2, 3'd2, 3'd3)};
    run = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    run = 1'b0;
    @(negedge clk);
    check_val("abort_t2_bus", {32'd0, bus_o}, 64'h6);
    #2 rst_n = 1'b0;
    #1;
    check_val("abort_bus", {32'd0, bus_o}, 64'd0);
    check_val("abort_done", {63'd0, done_o}, 64'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("abort_no_t3", {63'd0, done_o}, 64'd0);
    @(posedge clk); #1;
    rd("abort_r2", 3'd2, 32'h0000);

    // W=32 add wrap
    wide = 1'b1;
    exec("w32_mvi_r2", ins(3'd1, 3'd2, 3'd0), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exec("w32_mvi_r3", ins(3'd1, 3'd3, 3'd0), 32'h0000_0002, 32'h0000_0002);
    exec("w32_add", ins(3'd2, 3'd2, 3'd3), 32'h0, 32'h0000_0001);
    rd("w32_r2", 3'd2, 32'h0000_0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/proc_n.md
# proc_n

Parametrised successor to the lab's simple bus-based processor. Data width is configurable, the instruction set adds `and`, conditional move `mvnz` and defined no-ops, and the `Run` input gates instruction fetch. It sits between the board-level wrapper (switches drive `DIN` and `Run`; `BusWires` drives LEDs/7-seg) and will later front a memory interface. It contains eight W-bit general registers R0–R7, accumulator A, result register G, a 9-bit IR, one ALU and a one-hot-driven shared bus.

## Interface
- `W`, default 16: data/bus width. Legal range is 9 to 64, since IR is taken from `DIN[8:0]`.
- `Clock`  input  1: single clock. Everything samples on the rising edge.
- `Resetn`  input  1: asynchronous, active-low reset.
- `DIN`  input  W: instruction word while in T0; immediate operand while in T1 of `mvi`.
- `Run`  input  1: start request, sampled only in T0.
- `Done`  output  1: high during the final cycle of each instruction.
- `BusWires`  output  W: shared bus value, exported for display.

## Operation
- Instruction format is `IR[8:6]` = opcode, `IR[5:3]` = X, `IR[2:0]` = Y. IR loads `DIN[8:0]`.
- Opcodes:
  - 000 `mv` Rx←Ry
  - 001 `mvi` Rx←DIN
  - 010 `add` Rx←Rx+Ry
  - 011 `sub` Rx←Rx−Ry
  - 100 `and` Rx←Rx&Ry
  - 101 `mvnz` Rx←Ry if G≠0
  - 110, 111 are no-ops.
- FSM states are T0 (fetch/idle), T1, T2 and T3. It is a registered state plus combinational control decode.
- T0 behaviour:
  - If Run=1: IR←DIN[8:0] and go to T1.
  - Otherwise stay in T0, with IR unchanged.
- T1 behaviour:
  - `mv`: the bus carries Ry and Rx loads it. Done=1. Go to T0.
  - `mvi`: the bus carries DIN and Rx loads it. Done=1. Go to T0.
  - `mvnz`: the bus carries Ry. Rx loads only if G≠0. Done=1 either way. Go to T0.
  - no-op: the bus is idle. Done=1. Go to T0.
  - ALU ops: the bus carries Rx and A loads it. Go to T2.
- T2 (ALU ops only): the bus carries Ry, and G ← A op Bus. Go to T3.
- T3 (ALU ops only): the bus carries G and Rx loads it. Done=1. Go to T0.
- Arithmetic is modulo 2^W. There is no carry or overflow output. `sub` is two's complement (A + ~Bus + 1).
- G is written only by add/sub/and. `mvnz` tests the G value from the most recent ALU instruction.
- Bus sources are one-hot by construction: DIN, G, or R0–R7. When no source is selected (T0, no-op T1), BusWires = 0. There are no latches.
- X = Y is legal. `add R3,R3` doubles R3, and `sub R3,R3` gives 0.

## Timing
- Reset (Resetn=0, asynchronous): state=T0, IR=0, A=0, G=0, R0–R7=0. Outputs are then Done=0 and BusWires=0. Reset asserted mid-instruction aborts it, with no partial register write after the reset edge. Release is synchronous to the next `Clock` rising edge.
- `Done` is combinational from state and IR. It is high for exactly one cycle per instruction, and the destination write happens on the rising edge that ends that cycle.
- Latency from the edge that samples Run=1:
  - `mv`/`mvi`/`mvnz`/no-op: Done in the next cycle, 2 cycles total.
  - ALU ops: Done 3 cycles later, 4 cycles total.
- `mvi`: DIN must hold the immediate throughout the T1 cycle. DIN is don't-care in T2/T3.
- Run held high: the next instruction is fetched in the cycle after Done, with no bubble beyond T0. Run is ignored in T1–T3.
- Run low in T0: the processor idles indefinitely. BusWires=0 and no register changes.

## Test plan
- Reset then idle: hold Resetn=0, release, Run=0 for 5 cycles -> Done=0, BusWires=0, all registers 0. Pulse Resetn low between edges -> state returns to T0 immediately.
- `mvi R0,#0x0005` then `mv R1,R0` (W=16), Run held high -> Done in cycles 2 and 4. R0=R1=0x0005. BusWires=0x0005 in both T1 cycles.
- Load R2=0xFFFF, R3=0x0002, then `add R2,R3` -> R2=0x0001 (wrap). Then `sub R3,R3` -> R3=0x0000. Each ALU Done is 4 cycles after Run.
- `mvnz`: after `sub` giving G=0, `mvnz R4,R2` -> R4 unchanged, Done=1. After `add` giving G=0x0003, `mvnz R4,R2` -> R4=R2.
- `and` and no-ops: R5=0x0F0F, R6=0x00FF, `and R5,R6` -> R5=0x000F. Opcode 110 -> Done after 2 cycles, no register or G change.
- Abort and width: assert Resetn=0 during T2 of `add` -> Rx keeps 0, state=T0. Rerun the add/wrap scenario with W=32: 0xFFFFFFFF+2 -> 0x00000001.
